// File: rtl/mii_frame_checker.sv
// XGMII receive frame checker: tracks start/terminate framing, measures frame
// length, classifies the ending error and keeps good/errored frame counters.
module mii_frame_checker #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1525
) (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic [63:0] i_rxd,
   input  logic [7:0]  i_rxc,
   output logic        o_in_frame,
   output logic        o_frame_done,
   output logic [15:0] o_frame_len,
   output logic [2:0]  o_err_code,
   output logic [31:0] o_frame_cnt,
   output logic [15:0] o_err_cnt
);

   localparam logic [2:0]  ERR_NONE     = 3'd0;
   localparam logic [2:0]  ERR_BAD_CTRL = 3'd1;
   localparam logic [2:0]  ERR_BAD_TERM = 3'd2;
   localparam logic [2:0]  ERR_OVERSIZE = 3'd3;
   localparam logic [2:0]  ERR_RUNT     = 3'd4;
   localparam logic [15:0] MIN_L        = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L        = 16'(MAX_LEN);

   typedef enum logic {IDLE, DATA} state_t;

   state_t      state;
   logic [15:0] acc;

   logic        is_start;
   logic        is_idle;
   logic [2:0]  k;
   logic [7:0]  lane_k;
   logic        tail_bad;
   logic [15:0] final_len;
   logic [2:0]  end_code;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] a);
      return (a == 16'hFFFF) ? a : a + 16'd1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] a);
      return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
   endfunction

   // Beat decode: start/idle recognition and terminate-lane classification
   always_comb begin
      is_start = (i_rxc == 8'h01) && (i_rxd[7:0] == 8'hFB);
      is_idle  = (i_rxc == 8'hFF) && (i_rxd == 64'h0707_0707_0707_0707);
      k = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (i_rxc[i]) k = 3'(i);
      end
      lane_k   = i_rxd[{k, 3'b000} +: 8];
      tail_bad = 1'b0;
      for (int j = 0; j < 8; j++) begin
         if ((3'(j) > k) && (!i_rxc[j] || (i_rxd[8*j +: 8] != 8'h07))) tail_bad = 1'b1;
      end
      final_len = sat_add16(acc, {13'd0, k});
      if (lane_k != 8'hFD)        end_code = ERR_BAD_CTRL;
      else if (tail_bad)          end_code = ERR_BAD_TERM;
      else if (final_len > MAX_L) end_code = ERR_OVERSIZE;
      else if (final_len < MIN_L) end_code = ERR_RUNT;
      else                        end_code = ERR_NONE;
   end

   // Framing FSM with registered reporting outputs
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         acc          <= 16'd0;
         o_in_frame   <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_len  <= 16'd0;
         o_err_code   <= ERR_NONE;
         o_frame_cnt  <= 32'd0;
         o_err_cnt    <= 16'd0;
      end else begin
         o_frame_done <= 1'b0;
         if (i_valid) begin
            case (state)
               IDLE: begin
                  if (is_start) begin
                     state      <= DATA;
                     acc        <= 16'd7;
                     o_in_frame <= 1'b1;
                  end else if (!is_idle) begin
                     o_err_cnt <= sat_inc16(o_err_cnt);
                  end
               end
               DATA: begin
                  if (i_rxc == 8'h00) begin
                     acc <= sat_add16(acc, 16'd8);
                  end else begin
                     // Any control lane ends the frame, including a repeated start
                     state        <= IDLE;
                     acc          <= 16'd0;
                     o_in_frame   <= 1'b0;
                     o_frame_done <= 1'b1;
                     o_frame_len  <= final_len;
                     o_err_code   <= end_code;
                     if (end_code == ERR_NONE) o_frame_cnt <= sat_inc32(o_frame_cnt);
                     else                      o_err_cnt   <= sat_inc16(o_err_cnt);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
